// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and defaults for the data-memory controller.
//   size_e      : access size encoding (byte/half/word; 2'b11 is illegal)
//   state_e     : arbiter FSM states
//   DEPTH_WORDS_DEFAULT : default data-memory depth in 32-bit words
package dmem_ctrl_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane formatter.
//   size, offset, is_unsigned : access size, addr[1:0], load extension mode
//   wdata / rdata             : right-aligned store data / raw memory word
//   be, wd                    : byte enables and lane-replicated store data
//   ldata                     : selected and extended load result
//   misalign                  : half on odd address or word not on 4-byte boundary
module lsu_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be       = '0;
    wd       = wdata;
    ldata    = '0;
    misalign = 1'b0;
    rbyte    = rdata[{offset, 3'b000} +: 8];
    rhalf    = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B: begin
        be    = 4'b0001 << offset;
        wd    = {4{wdata[7:0]}};
        ldata = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        be       = 4'b0011 << offset;
        wd       = {2{wdata[15:0]}};
        ldata    = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        misalign = offset[0];
      end
      SZ_W: begin
        be       = '1;
        ldata    = rdata;
        misalign = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core LSU = 0, DMA = 1) round-robin arbiter in front of
// a single-cycle-latency data memory. One transaction outstanding: grant and
// memory access in cycle T, response pulse in T+1.
//   clk, reset_n            : clock, synchronous active-low reset
//   rN_valid/ready/we/size/unsigned/addr/wdata : request ports N=0,1
//   rsp_valid/id/rdata/err  : response (all zero when rsp_valid=0)
//   mem_en/we/be/a/wd, mem_rd : memory interface
module dmem_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic          r0_we,
  input  logic [1:0]    r0_size,
  input  logic          r0_unsigned,
  input  logic [AW-1:0] r0_addr,
  input  logic [31:0]   r0_wdata,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_we,
  input  logic [1:0]    r1_size,
  input  logic          r1_unsigned,
  input  logic [AW-1:0] r1_addr,
  input  logic [31:0]   r1_wdata,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  state_e        state_q;
  logic          last_grant;
  logic          ctx_id, ctx_we, ctx_err, ctx_uns;
  logic [1:0]    ctx_size, ctx_off;

  logic          issue, gnt_id, err;
  logic          sel_we, sel_uns;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr, word_idx;
  logic [31:0]   sel_wdata;

  logic [1:0]    al_size, al_off;
  logic          al_uns, al_misalign;
  logic [3:0]    al_be;
  logic [31:0]   al_wd, al_ldata;

  // Both valid: the port not granted last wins; otherwise the lone valid port.
  assign gnt_id = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
  assign issue  = reset_n && (state_q == IDLE) && (r0_valid || r1_valid);

  assign sel_we    = gnt_id ? r1_we       : r0_we;
  assign sel_size  = gnt_id ? r1_size     : r0_size;
  assign sel_uns   = gnt_id ? r1_unsigned : r0_unsigned;
  assign sel_addr  = gnt_id ? r1_addr     : r0_addr;
  assign sel_wdata = gnt_id ? r1_wdata    : r0_wdata;

  assign word_idx = {2'b00, sel_addr[AW-1:2]};
  assign err      = al_misalign || (sel_size == 2'b11) || (word_idx >= AW'(DEPTH_WORDS));

  // One formatter serves both phases: the live request while issuing,
  // the registered context while the read data returns.
  assign al_size = (state_q == WAIT) ? ctx_size : sel_size;
  assign al_off  = (state_q == WAIT) ? ctx_off  : sel_addr[1:0];
  assign al_uns  = (state_q == WAIT) ? ctx_uns  : sel_uns;

  lsu_align u_align (
    .size        (al_size),
    .offset      (al_off),
    .is_unsigned (al_uns),
    .wdata       (sel_wdata),
    .rdata       (mem_rd),
    .be          (al_be),
    .wd          (al_wd),
    .ldata       (al_ldata),
    .misalign    (al_misalign)
  );

  assign r0_ready = issue && !gnt_id;
  assign r1_ready = issue &&  gnt_id;

  assign mem_en = issue && !err;
  assign mem_we = issue && !err && sel_we;
  assign mem_be = mem_we ? al_be : '0;
  assign mem_a  = reset_n ? sel_addr : '0;
  assign mem_wd = reset_n ? al_wd : '0;

  assign rsp_valid = reset_n && (state_q == WAIT);
  assign rsp_id    = rsp_valid && ctx_id;
  assign rsp_err   = rsp_valid && ctx_err;
  assign rsp_rdata = (rsp_valid && !ctx_we && !ctx_err) ? al_ldata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      ctx_id     <= 1'b0;
      ctx_we     <= 1'b0;
      ctx_err    <= 1'b0;
      ctx_uns    <= 1'b0;
      ctx_size   <= '0;
      ctx_off    <= '0;
    end else begin
      case (state_q)
        IDLE: if (issue) begin
          state_q    <= WAIT;
          last_grant <= gnt_id;
          ctx_id     <= gnt_id;
          ctx_we     <= sel_we;
          ctx_err    <= err;
          ctx_uns    <= sel_uns;
          ctx_size   <= sel_size;
          ctx_off    <= sel_addr[1:0];
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v[2], we_[2], un[2];
  logic [1:0]  sz[2];
  logic [31:0] ad[2], wdat[2];

  logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata, mem_wd, mem_a;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rd = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(64), .AW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(v[0]), .r0_ready(r0_ready), .r0_we(we_[0]), .r0_size(sz[0]),
    .r0_unsigned(un[0]), .r0_addr(ad[0]), .r0_wdata(wdat[0]),
    .r1_valid(v[1]), .r1_ready(r1_ready), .r1_we(we_[1]), .r1_size(sz[1]),
    .r1_unsigned(un[1]), .r1_addr(ad[1]), .r1_wdata(wdat[1]),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory the DUT drives: 64 words, one-cycle read latency.
  logic [31:0] ram[64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      mem_rd <= ram[mem_a[7:2]];
    end
  end

  // Reference model state: byte-addressed shadow memory plus protocol state.
  logic [7:0]  sh[256];
  bit          m_wait, m_last;
  bit          p_id, p_err;
  logic [31:0] p_rdata;

  int n_checks = 0, n_fail = 0;
  logic [31:0] obs_be, obs_wd, obs_rdata;
  bit obs_en, obs_err, obs_id, obs_gnt, obs_rv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input bit u);
    logic [31:0] val;
    int nb = 1 << s;
    val = 0;
    for (int i = nb - 1; i >= 0; i--) val = val * 256 + sh[a + i];
    if (!u && nb == 1 && val >= 128)   val = val + 32'hFFFF_FF00;
    if (!u && nb == 2 && val >= 32768) val = val + 32'hFFFF_0000;
    return val;
  endfunction

  task automatic step();
    @(negedge clk);
    obs_rv = rsp_valid;
    if (!reset_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ready", {r1_ready, r0_ready}, 0);
      check("rst_mem", {mem_en, mem_we, mem_be}, 0);
      check("rst_rsp", {rsp_id, rsp_err, rsp_rdata[29:0]}, 0);
      m_wait = 0; m_last = 1;
    end else if (m_wait) begin
      check("wait_ready", {r1_ready, r0_ready}, 0);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, p_id);
      check("rsp_err", rsp_err, p_err);
      check("rsp_rdata", rsp_rdata, p_rdata);
      check("wait_mem_en", mem_en, 0);
      obs_rdata = rsp_rdata; obs_err = rsp_err; obs_id = rsp_id;
      m_wait = 0;
    end else begin
      check("idle_rsp", {rsp_valid, rsp_id, rsp_err}, 0);
      check("idle_rdata", rsp_rdata, 0);
      if (v[0] || v[1]) begin
        int g, nb;
        bit e, w;
        logic [31:0] a, d, exp_be, exp_wd;
        g  = (v[0] && v[1]) ? !m_last : (v[1] ? 1 : 0);
        a  = ad[g]; d = wdat[g]; w = we_[g];
        nb = 1 << sz[g];
        e  = (sz[g] == 3) || (a % nb != 0) || (a / 4 >= 64);
        exp_be = ((1 << nb) - 1) << (a % 4);
        exp_wd = (nb == 4) ? d : (nb == 2) ? (d % 65536) * 32'h0001_0001 : (d % 256) * 32'h0101_0101;
        check("ready0", r0_ready, g == 0);
        check("ready1", r1_ready, g == 1);
        check("mem_en", mem_en, !e);
        check("mem_we", mem_we, !e && w);
        check("mem_be", mem_be, (!e && w) ? exp_be : 0);
        if (!e) check("mem_a", mem_a, a);
        if (!e && w) begin
          check("mem_wd", mem_wd, exp_wd);
          for (int i = 0; i < nb; i++) sh[a + i] = exp_wd[8*((a + i) % 4) +: 8];
        end
        obs_en = mem_en; obs_be = mem_be; obs_wd = mem_wd; obs_gnt = r1_ready;
        p_id = g[0]; p_err = e;
        p_rdata = (e || w) ? 0 : model_load(a, sz[g], un[g]);
        m_wait = 1; m_last = g[0];
      end else begin
        check("noreq_ready", {r1_ready, r0_ready}, 0);
        check("noreq_mem_en", mem_en, 0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      v[p] = 0; we_[p] = 0; sz[p] = 0; un[p] = 0; ad[p] = 0; wdat[p] = 0;
    end
  endtask

  task automatic set_port(input int p, input bit w, input logic [1:0] s, input bit u,
                          input logic [31:0] a, input logic [31:0] d);
    v[p] = 1; we_[p] = w; sz[p] = s; un[p] = u; ad[p] = a; wdat[p] = d;
  endtask

  task automatic req(input int p, input bit w, input logic [1:0] s, input bit u,
                     input logic [31:0] a, input logic [31:0] d);
    clear_inputs();
    set_port(p, w, s, u, a, d);
    step();
    clear_inputs();
    step();
  endtask

  task automatic do_reset();
    reset_n = 0; clear_inputs();
    step(); step();
    reset_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int i = 0; i < 256; i++) sh[i] = '0;
    m_wait = 0; m_last = 1;
    clear_inputs();
    @(posedge clk); #1;
    do_reset();

    // Store/load word round trip on port 0.
    req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    check("sw_be", obs_be, 4'hF);
    req(0, 0, 2'b10, 0, 32'h10, 0);
    check("lw_data", obs_rdata, 32'hDEADBEEF);
    check("lw_id", obs_id, 0);

    // Sign/zero extension.
    req(0, 1, 2'b10, 0, 32'h10, 32'h80FF7F01);
    req(0, 0, 2'b00, 0, 32'h13, 0);
    check("lb_signed", obs_rdata, 32'hFFFFFF80);
    req(0, 0, 2'b00, 1, 32'h13, 0);
    check("lbu", obs_rdata, 32'h00000080);
    req(0, 0, 2'b01, 0, 32'h12, 0);
    check("lh_signed", obs_rdata, 32'hFFFF80FF);

    // Byte store from port 1 leaves other lanes intact.
    req(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    req(1, 1, 2'b00, 0, 32'h21, 32'h000000AB);
    check("sb_be", obs_be, 4'b0010);
    check("sb_wd", obs_wd, 32'hABABABAB);
    req(1, 0, 2'b10, 0, 32'h20, 0);
    check("sb_readback", obs_rdata, 32'h1122AB44);
    check("sb_rsp_id", obs_id, 1);

    // Error cases: accepted, answered with err, no memory access.
    req(0, 0, 2'b10, 0, 32'h06, 0);
    check("err_lw_en", obs_en, 0); check("err_lw", obs_err, 1); check("err_lw_rd", obs_rdata, 0);
    req(0, 0, 2'b01, 0, 32'h03, 0);
    check("err_lh_en", obs_en, 0); check("err_lh", obs_err, 1);
    req(1, 1, 2'b11, 0, 32'h08, 32'h12345678);
    check("err_sz_en", obs_en, 0); check("err_sz", obs_err, 1);
    req(0, 0, 2'b10, 0, 32'h100, 0);
    check("err_rng_en", obs_en, 0); check("err_rng", obs_err, 1); check("err_rng_rd", obs_rdata, 0);

    // Round-robin with both ports continuously valid after reset.
    do_reset();
    set_port(0, 0, 2'b10, 0, 32'h10, 0);
    set_port(1, 0, 2'b10, 0, 32'h20, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i % 2 == 0) check("rr_grant", obs_gnt, (i / 2) % 2);
      else            check("rr_rsp", obs_rv, 1);
    end

    // Reset while waiting drops the response; port 0 wins next.
    clear_inputs();
    step();
    set_port(0, 0, 2'b10, 0, 32'h10, 0);
    step();
    clear_inputs();
    reset_n = 0;
    step();
    check("rst_drop", obs_rv, 0);
    reset_n = 1;
    step();
    check("post_rst_idle", obs_rv, 0);
    set_port(0, 0, 2'b10, 0, 32'h10, 0);
    set_port(1, 0, 2'b10, 0, 32'h20, 0);
    step();
    check("post_rst_grant", obs_gnt, 0);
    clear_inputs();
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        logic [1:0]  s;
        logic [31:0] a;
        v[p]    = ($urandom_range(0, 3) != 0);
        we_[p]  = $urandom_range(0, 1);
        un[p]   = $urandom_range(0, 1);
        s       = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a       = ($urandom_range(0, 15) == 0) ? 32'h100 + $urandom_range(0, 255) : $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0 && s != 2'b11) a = a & ~((32'd1 << s) - 1);
        sz[p]   = s;
        ad[p]   = a;
        wdat[p] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) reset_n = 0; else reset_n = 1;
      step();
    end
    reset_n = 1;
    clear_inputs();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
